dma_desc_sched: RTL and testbench
=================================

# dma_desc_sched

Multi-channel descriptor queue and scheduler for the DMA. It sits between the CSR block and the streamer. Each of NUM_CH channels owns a DESC_DEPTH-entry descriptor FIFO. A round-robin arbiter issues one descriptor at a time to the streamer and tracks completion and errors per channel. It replaces the fixed two-descriptor, single-channel handoff with a parametrised queue that supports abort and per-channel sticky status.

## Interface
Parameters:
- NUM_CH, 4: number of channels, 1..16.
- DESC_DEPTH, 4: FIFO entries per channel; power of 2, at least 2.
- ADDR_WIDTH, 32: width of the source and destination address fields.
- BYTES_WIDTH, 32: width of the byte-count field.
- Derived: DW = 2*ADDR_WIDTH+BYTES_WIDTH; CW = max(1,$clog2(NUM_CH)); LW = $clog2(DESC_DEPTH)+1.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- ch_desc_valid_i  in  NUM_CH  per-channel push request.
- ch_desc_ready_o  out  NUM_CH  per-channel push accept.
- ch_desc_i  in  NUM_CH*DW  per-channel descriptor {src_addr, dst_addr, num_bytes}; channel c occupies bits [c*DW +: DW].
- ch_abort_i  in  NUM_CH  flush that channel's pending (not yet issued) entries.
- ch_clear_i  in  NUM_CH  clear that channel's sticky done and error.
- issue_valid_o  out  1  descriptor offered to the streamer.
- issue_ready_i  in  1  streamer accepts.
- issue_desc_o  out  DW  offered descriptor.
- issue_ch_o  out  CW  channel that owns the offered descriptor.
- done_i  in  1  streamer completion pulse for the in-flight descriptor.
- err_i  in  1  streamer error pulse for the in-flight descriptor.
- err_src_i  in  2  error source code (rd/wr/unaligned/narrow-cross encoding).
- err_addr_i  in  ADDR_WIDTH  faulting address.
- ch_status_o  out  NUM_CH*3  per-channel {error, done, active}.
- ch_level_o  out  NUM_CH*LW  per-channel FIFO occupancy.
- err_ch_o, err_src_o, err_addr_o  out  CW/2/ADDR_WIDTH  last captured error.

## Operation
- Push on channel c requires ch_desc_valid_i[c] && ch_desc_ready_o[c].
  - ch_desc_ready_o[c] = level[c] < DESC_DEPTH && !error[c] && !ch_abort_i[c].
  - An accepted push clears done[c].
- FSM states:
  - IDLE: if any channel has level > 0, grant the first non-empty channel at or after rr_ptr (wrapping) and pop its head.
    - Popped num_bytes == 0: do not issue; treat as a successful completion; stay in IDLE.
    - Otherwise load issue_desc_o/issue_ch_o and go to ISSUE.
    - rr_ptr becomes grant+1 mod NUM_CH on every grant.
  - ISSUE: hold issue_valid_o=1 with a stable payload until issue_ready_i, then go to BUSY.
  - BUSY: wait for done_i or err_i, then return to IDLE.
    - err_i wins if both arrive in the same cycle.
    - done_i/err_i outside BUSY are ignored.
- Successful completion on channel c:
  - Sets done[c] if level[c]==0 at that cycle.
  - A push in the same cycle still counts as level 0, so done sets and the push then clears it next cycle.
- Error on channel c:
  - Sets error[c].
  - Flushes c's FIFO (level becomes 0).
  - Captures err_ch_o/err_src_o/err_addr_o.
  - Later errors overwrite the capture.
- active[c] = level[c] > 0 || (state != IDLE && issue_ch_o == c).
- Abort on c:
  - Sets level[c] to 0 next cycle.
  - Does not affect an in-flight descriptor of c, which completes normally.
  - Abort and push on c in the same cycle: abort wins and the push is refused (ready low).
- ch_clear_i[c] clears done[c] and error[c]. If a completion event sets a bit in the same cycle, the set wins.
- Reset mid-transfer drops the in-flight descriptor; a pending done_i arriving afterwards is ignored.

## Timing
- Reset values:
  - issue_valid_o=0, issue_desc_o=0, issue_ch_o=0.
  - ch_desc_ready_o all 1, since levels are 0 and no errors are set.
  - ch_status_o=0, ch_level_o=0.
  - err_*_o=0, rr_ptr=0, state IDLE.
- Push accepted at cycle T: ch_level_o increments at T+1; the entry is eligible for grant at T+1.
- Grant in IDLE at cycle T: issue_valid_o=1 from T+1.
- Handshake at T: BUSY from T+1.
- done_i at T: status updates visible at T+1, IDLE at T+1, next issue_valid_o at T+2 at the earliest.
- At most one descriptor is outstanding. Steady-state issue gap is 2 cycles after done_i.
- FIFO pointers wrap modulo DESC_DEPTH. Push and pop on the same channel in the same cycle leave the level unchanged.

## Test plan
- Reset, then push 3 descriptors on ch0 (num_bytes=64): issues in order; done_i after each; ch0 status reads {0,1,0} only after the third; ch_level_o[0] goes 3→0.
- Push 1 descriptor on each of ch0..ch3 simultaneously, issue_ready_i=1: issue_ch_o sequence is 0,1,2,3; next round starts at ch0.
- Fill ch1 with DESC_DEPTH entries: ch_desc_ready_o[1]=0; the extra push is not accepted; after one pop, ready=1 and the level wraps correctly.
- ch2 has 3 queued, first in flight; err_i with err_src_i=1, err_addr_i=0x1000: ch2 level=0, error=1, err_ch_o=2, err_addr_o=0x1000; ready[2]=0 until ch_clear_i[2].
- Push with num_bytes=0 on ch3: issue_valid_o never asserts; done[3]=1 two cycles after the push.
- ch0 has 2 queued with one in flight; assert ch_abort_i[0] together with a push: push refused, level=0; done_i sets done[0].

Source files
------------

// File: rtl/dma_desc_sched.sv
// dma_desc_sched: per-channel descriptor FIFOs feeding a single streamer
// through a round-robin arbiter, with per-channel sticky done/error status,
// abort (flush of queued entries) and capture of the most recent error.
//
// state  | meaning
// IDLE   | no descriptor outstanding; arbitrate and pop a head entry
// ISSUE  | descriptor offered on issue_*; waiting for issue_ready_i
// BUSY   | descriptor accepted by streamer; waiting for done_i / err_i
module dma_desc_sched #(
  parameter int NUM_CH      = 4,
  parameter int DESC_DEPTH  = 4,
  parameter int ADDR_WIDTH  = 32,
  parameter int BYTES_WIDTH = 32,
  localparam int DW = 2*ADDR_WIDTH + BYTES_WIDTH,
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int LW = $clog2(DESC_DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        ch_desc_valid_i,
  output logic [NUM_CH-1:0]        ch_desc_ready_o,
  input  logic [NUM_CH*DW-1:0]     ch_desc_i,
  input  logic [NUM_CH-1:0]        ch_abort_i,
  input  logic [NUM_CH-1:0]        ch_clear_i,
  output logic                     issue_valid_o,
  input  logic                     issue_ready_i,
  output logic [DW-1:0]            issue_desc_o,
  output logic [CW-1:0]            issue_ch_o,
  input  logic                     done_i,
  input  logic                     err_i,
  input  logic [1:0]               err_src_i,
  input  logic [ADDR_WIDTH-1:0]    err_addr_i,
  output logic [NUM_CH*3-1:0]      ch_status_o,
  output logic [NUM_CH*LW-1:0]     ch_level_o,
  output logic [CW-1:0]            err_ch_o,
  output logic [1:0]               err_src_o,
  output logic [ADDR_WIDTH-1:0]    err_addr_o
);

  localparam int PW = $clog2(DESC_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_BUSY  = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [DW-1:0]         mem_q    [NUM_CH][DESC_DEPTH];
  logic [PW-1:0]         wr_ptr_q [NUM_CH];
  logic [PW-1:0]         wr_ptr_d [NUM_CH];
  logic [PW-1:0]         rd_ptr_q [NUM_CH];
  logic [PW-1:0]         rd_ptr_d [NUM_CH];
  logic [LW-1:0]         level_q  [NUM_CH];
  logic [LW-1:0]         level_d  [NUM_CH];
  logic [NUM_CH-1:0]     done_q, done_d;
  logic [NUM_CH-1:0]     error_q, error_d;
  logic [NUM_CH-1:0]     clr_pend_q, clr_pend_d;
  logic [CW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [DW-1:0]         issue_desc_q, issue_desc_d;
  logic [CW-1:0]         issue_ch_q, issue_ch_d;
  logic [CW-1:0]         err_ch_q, err_ch_d;
  logic [1:0]            err_src_q, err_src_d;
  logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;

  logic [NUM_CH-1:0]     push_acc;
  logic [NUM_CH-1:0]     pop;
  logic                  grant_vld;
  logic [CW-1:0]         grant_ch;
  logic [DW-1:0]         head_desc;
  logic                  head_zero;
  logic                  comp_vld;
  logic [CW-1:0]         comp_ch;
  logic                  err_evt;
  logic [NUM_CH-1:0]     comp_hit, err_hit, flush, set_done;

  // Push acceptance: room left, channel not in error, not being aborted this cycle
  always_comb begin
    ch_desc_ready_o = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      ch_desc_ready_o[c] = (level_q[c] < LW'(DESC_DEPTH)) && !error_q[c] && !ch_abort_i[c];
    end
    push_acc = ch_desc_valid_i & ch_desc_ready_o;
  end

  // Round-robin pick of the first non-empty channel at or after rr_ptr; an
  // aborting channel is skipped so its flushed head can never be issued
  always_comb begin
    int idx;
    logic [CW-1:0] idx_c;
    grant_vld = 1'b0;
    grant_ch  = '0;
    idx       = 0;
    idx_c     = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      idx   = (int'(rr_ptr_q) + i) % NUM_CH;
      idx_c = CW'(idx);
      if ((level_q[idx_c] != '0) && !ch_abort_i[idx_c]) begin
        grant_vld = 1'b1;
        grant_ch  = idx_c;
      end
    end
    head_desc = mem_q[grant_ch][rd_ptr_q[grant_ch]];
    head_zero = (head_desc[BYTES_WIDTH-1:0] == '0);
  end

  // Scheduler next-state: grant/pop in IDLE, handshake in ISSUE, completion in BUSY
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    issue_desc_d = issue_desc_q;
    issue_ch_d   = issue_ch_q;
    pop          = '0;
    comp_vld     = 1'b0;
    comp_ch      = '0;
    err_evt      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (grant_vld) begin
          pop[grant_ch] = 1'b1;
          rr_ptr_d      = (grant_ch == CW'(NUM_CH - 1)) ? '0 : grant_ch + CW'(1);
          if (head_zero) begin
            // zero-length descriptor completes immediately without a streamer transfer
            comp_vld = 1'b1;
            comp_ch  = grant_ch;
          end else begin
            issue_desc_d = head_desc;
            issue_ch_d   = grant_ch;
            state_d      = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (issue_ready_i) state_d = ST_BUSY;
      end
      ST_BUSY: begin
        if (err_i) begin
          err_evt = 1'b1;
          state_d = ST_IDLE;
        end else if (done_i) begin
          comp_vld = 1'b1;
          comp_ch  = issue_ch_q;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Per-channel FIFO pointers, levels and sticky status bits
  always_comb begin
    comp_hit   = '0;
    err_hit    = '0;
    flush      = '0;
    set_done   = '0;
    done_d     = done_q;
    error_d    = error_q;
    clr_pend_d = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      comp_hit[c] = comp_vld && (comp_ch == CW'(c));
      err_hit[c]  = err_evt && (issue_ch_q == CW'(c));
      flush[c]    = err_hit[c] || ch_abort_i[c];
      // a push in the completion cycle does not count toward the remaining level
      set_done[c] = comp_hit[c] && ((level_q[c] - LW'(pop[c])) == '0);

      wr_ptr_d[c] = wr_ptr_q[c] + PW'(push_acc[c]);
      rd_ptr_d[c] = rd_ptr_q[c] + PW'(pop[c]);
      level_d[c]  = level_q[c] + LW'(push_acc[c]) - LW'(pop[c]);
      if (flush[c]) begin
        rd_ptr_d[c] = wr_ptr_d[c];
        level_d[c]  = '0;
      end

      // a push that collides with a done set clears done one cycle later
      clr_pend_d[c] = set_done[c] && push_acc[c];
      if (set_done[c])
        done_d[c] = 1'b1;
      else if (push_acc[c] || ch_clear_i[c] || clr_pend_q[c])
        done_d[c] = 1'b0;

      if (err_hit[c])
        error_d[c] = 1'b1;
      else if (ch_clear_i[c])
        error_d[c] = 1'b0;
    end
  end

  // Last-error capture; later errors overwrite
  always_comb begin
    err_ch_d   = err_ch_q;
    err_src_d  = err_src_q;
    err_addr_d = err_addr_q;
    if (err_evt) begin
      err_ch_d   = issue_ch_q;
      err_src_d  = err_src_i;
      err_addr_d = err_addr_i;
    end
  end

  // Descriptor storage; contents need no reset since level gates every read
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (push_acc[c]) mem_q[c][wr_ptr_q[c]] <= ch_desc_i[c*DW +: DW];
    end
  end

  // State and control registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      rr_ptr_q     <= '0;
      issue_desc_q <= '0;
      issue_ch_q   <= '0;
      done_q       <= '0;
      error_q      <= '0;
      clr_pend_q   <= '0;
      err_ch_q     <= '0;
      err_src_q    <= '0;
      err_addr_q   <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        wr_ptr_q[c] <= '0;
        rd_ptr_q[c] <= '0;
        level_q[c]  <= '0;
      end
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      issue_desc_q <= issue_desc_d;
      issue_ch_q   <= issue_ch_d;
      done_q       <= done_d;
      error_q      <= error_d;
      clr_pend_q   <= clr_pend_d;
      err_ch_q     <= err_ch_d;
      err_src_q    <= err_src_d;
      err_addr_q   <= err_addr_d;
      for (int c = 0; c < NUM_CH; c++) begin
        wr_ptr_q[c] <= wr_ptr_d[c];
        rd_ptr_q[c] <= rd_ptr_d[c];
        level_q[c]  <= level_d[c];
      end
    end
  end

  // Status and level packing; a channel stays active while its descriptor is outstanding
  always_comb begin
    ch_status_o = '0;
    ch_level_o  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      ch_status_o[c*3 +: 3] = {error_q[c], done_q[c],
                               (level_q[c] != '0) ||
                               ((state_q != ST_IDLE) && (issue_ch_q == CW'(c)))};
      ch_level_o[c*LW +: LW] = level_q[c];
    end
  end

  assign issue_valid_o = (state_q == ST_ISSUE);
  assign issue_desc_o  = issue_desc_q;
  assign issue_ch_o    = issue_ch_q;
  assign err_ch_o      = err_ch_q;
  assign err_src_o     = err_src_q;
  assign err_addr_o    = err_addr_q;

endmodule

// File: tb/tb_dma_desc_sched.sv
// Bench for dma_desc_sched: scenario tasks with a scoreboard of expected
// issued descriptors checked by a monitor at every issue handshake.
module tb_dma_desc_sched;

  localparam int NUM_CH = 4;
  localparam int DEPTH  = 4;
  localparam int AW     = 32;
  localparam int BW     = 32;
  localparam int DW     = 2*AW + BW;
  localparam int CW     = 2;
  localparam int LW     = 3;

  logic                 clk;
  logic                 rst;
  logic [NUM_CH-1:0]    ch_desc_valid_i;
  logic [NUM_CH-1:0]    ch_desc_ready_o;
  logic [NUM_CH*DW-1:0] ch_desc_i;
  logic [NUM_CH-1:0]    ch_abort_i;
  logic [NUM_CH-1:0]    ch_clear_i;
  logic                 issue_valid_o;
  logic                 issue_ready_i;
  logic [DW-1:0]        issue_desc_o;
  logic [CW-1:0]        issue_ch_o;
  logic                 done_i;
  logic                 err_i;
  logic [1:0]           err_src_i;
  logic [AW-1:0]        err_addr_i;
  logic [NUM_CH*3-1:0]  ch_status_o;
  logic [NUM_CH*LW-1:0] ch_level_o;
  logic [CW-1:0]        err_ch_o;
  logic [1:0]           err_src_o;
  logic [AW-1:0]        err_addr_o;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [CW-1:0] ch;
    logic [DW-1:0] desc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  dma_desc_sched #(
    .NUM_CH(NUM_CH), .DESC_DEPTH(DEPTH), .ADDR_WIDTH(AW), .BYTES_WIDTH(BW)
  ) dut (
    .clk(clk), .rst(rst),
    .ch_desc_valid_i(ch_desc_valid_i), .ch_desc_ready_o(ch_desc_ready_o),
    .ch_desc_i(ch_desc_i), .ch_abort_i(ch_abort_i), .ch_clear_i(ch_clear_i),
    .issue_valid_o(issue_valid_o), .issue_ready_i(issue_ready_i),
    .issue_desc_o(issue_desc_o), .issue_ch_o(issue_ch_o),
    .done_i(done_i), .err_i(err_i), .err_src_i(err_src_i), .err_addr_i(err_addr_i),
    .ch_status_o(ch_status_o), .ch_level_o(ch_level_o),
    .err_ch_o(err_ch_o), .err_src_o(err_src_o), .err_addr_o(err_addr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard monitor: a handshake completes on the next rising edge
  always @(negedge clk) begin
    if (!rst && issue_valid_o && issue_ready_i) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL issue_unexpected: got ch=%0d desc=%h, required no issue", issue_ch_o, issue_desc_o);
      end else begin
        mon_e = sb.pop_front();
        if ({issue_ch_o, issue_desc_o} !== {mon_e.ch, mon_e.desc}) begin
          bad++;
          $display("FAIL issue_payload: got ch=%0d desc=%h, required ch=%0d desc=%h",
                   issue_ch_o, issue_desc_o, mon_e.ch, mon_e.desc);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [DW-1:0] mk(input logic [31:0] s, input logic [31:0] d, input logic [31:0] n);
    return {s, d, n};
  endfunction

  function automatic logic [LW-1:0] lvl(input int c);
    return ch_level_o[c*LW +: LW];
  endfunction

  function automatic logic [2:0] sts(input int c);
    return ch_status_o[c*3 +: 3];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    ch_desc_valid_i = '0;
    ch_desc_i = '0;
    ch_abort_i = '0;
    ch_clear_i = '0;
    issue_ready_i = 1'b0;
    done_i = 1'b0;
    err_i = 1'b0;
    err_src_i = '0;
    err_addr_i = '0;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  task automatic do_push(input int c, input logic [DW-1:0] d, input bit enq, output bit acc);
    exp_t e;
    ch_desc_valid_i[c] = 1'b1;
    ch_desc_i[c*DW +: DW] = d;
    @(negedge clk);
    acc = ch_desc_ready_o[c];
    if (acc && enq) begin
      e.ch = CW'(c);
      e.desc = d;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    ch_desc_valid_i[c] = 1'b0;
  endtask

  task automatic wait_issue(input string nm);
    int n;
    n = 0;
    while (!issue_valid_o && n < 40) begin
      tick();
      n++;
    end
    if (!issue_valid_o) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got issue_valid_o=0 after %0d cycles, required 1", nm, n);
    end
  endtask

  task automatic handshake();
    issue_ready_i = 1'b1;
    tick();
    issue_ready_i = 1'b0;
  endtask

  task automatic complete(input bit e, input bit d);
    err_i = e;
    done_i = d;
    tick();
    err_i = 1'b0;
    done_i = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    total++;
    if ({issue_valid_o, issue_desc_o, issue_ch_o} !== '0) begin
      bad++;
      $display("FAIL reset_issue: got v=%b ch=%0d desc=%h, required all 0", issue_valid_o, issue_ch_o, issue_desc_o);
    end
    total++;
    if (ch_desc_ready_o !== 4'hF) begin
      bad++;
      $display("FAIL reset_ready: got %b, required 1111", ch_desc_ready_o);
    end
    total++;
    if (ch_status_o !== '0 || ch_level_o !== '0) begin
      bad++;
      $display("FAIL reset_status: got status=%h level=%h, required 0/0", ch_status_o, ch_level_o);
    end
    total++;
    if ({err_ch_o, err_src_o, err_addr_o} !== '0) begin
      bad++;
      $display("FAIL reset_err: got ch=%0d src=%0d addr=%h, required 0", err_ch_o, err_src_o, err_addr_o);
    end
  endtask

  task automatic test_in_order();
    bit acc;
    logic [DW-1:0] a;
    apply_reset();
    a = mk(32'h100, 32'h200, 32'd16);
    do_push(1, a, 1'b1, acc);
    for (int k = 0; k < 3; k++)
      do_push(0, mk(32'h1000 + k*64, 32'h8000 + k*64, 32'd64), 1'b1, acc);
    total++;
    if (lvl(0) !== 3'd3 || sts(0) !== 3'b001) begin
      bad++;
      $display("FAIL inord_level3: got level=%0d status=%b, required 3/001", lvl(0), sts(0));
    end
    total++;
    if (issue_valid_o !== 1'b1 || issue_ch_o !== 2'd1 || issue_desc_o !== a) begin
      bad++;
      $display("FAIL inord_hold: got v=%b ch=%0d desc=%h, required 1/1/%h", issue_valid_o, issue_ch_o, issue_desc_o, a);
    end
    handshake();
    complete(1'b0, 1'b1);
    total++;
    if (sts(1) !== 3'b010) begin
      bad++;
      $display("FAIL inord_ch1_done: got %b, required 010", sts(1));
    end
    for (int k = 0; k < 3; k++) begin
      wait_issue("inord");
      total++;
      if (issue_ch_o !== 2'd0 || lvl(0) !== LW'(2 - k)) begin
        bad++;
        $display("FAIL inord_issue%0d: got ch=%0d level=%0d, required 0/%0d", k, issue_ch_o, lvl(0), 2 - k);
      end
      handshake();
      complete(1'b0, 1'b1);
      total++;
      if (sts(0) !== ((k < 2) ? 3'b001 : 3'b010)) begin
        bad++;
        $display("FAIL inord_status%0d: got %b, required %b", k, sts(0), (k < 2) ? 3'b001 : 3'b010);
      end
    end
  endtask

  task automatic test_round_robin();
    exp_t e;
    int order [2];
    apply_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      ch_desc_valid_i[c] = 1'b1;
      ch_desc_i[c*DW +: DW] = mk(32'h2000 + c, 32'h3000 + c, 32'd8 * (c + 1));
      e.ch = CW'(c);
      e.desc = mk(32'h2000 + c, 32'h3000 + c, 32'd8 * (c + 1));
      sb.push_back(e);
    end
    tick();
    ch_desc_valid_i = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      wait_issue("rr");
      total++;
      if (issue_ch_o !== CW'(k)) begin
        bad++;
        $display("FAIL rr_order%0d: got ch=%0d, required %0d", k, issue_ch_o, k);
      end
      handshake();
      complete(1'b0, 1'b1);
    end
    total++;
    if (ch_status_o !== 12'b010_010_010_010) begin
      bad++;
      $display("FAIL rr_done_all: got %b, required 010010010010", ch_status_o);
    end
    order[0] = 0;
    order[1] = 3;
    for (int i = 0; i < 2; i++) begin
      ch_desc_valid_i[order[i]] = 1'b1;
      ch_desc_i[order[i]*DW +: DW] = mk(32'h7000, 32'h7100 + order[i], 32'd4);
      e.ch = CW'(order[i]);
      e.desc = mk(32'h7000, 32'h7100 + order[i], 32'd4);
      sb.push_back(e);
    end
    tick();
    ch_desc_valid_i = '0;
    for (int i = 0; i < 2; i++) begin
      wait_issue("rr2");
      total++;
      if (issue_ch_o !== CW'(order[i])) begin
        bad++;
        $display("FAIL rr_round2_%0d: got ch=%0d, required %0d", i, issue_ch_o, order[i]);
      end
      handshake();
      complete(1'b0, 1'b1);
    end
  endtask

  task automatic test_full();
    bit acc;
    apply_reset();
    do_push(0, mk(32'h10, 32'h20, 32'd32), 1'b1, acc);
    for (int k = 0; k < DEPTH; k++)
      do_push(1, mk(32'hA000 + k, 32'hB000 + k, 32'd100 + k), 1'b1, acc);
    total++;
    if (lvl(1) !== 3'd4 || ch_desc_ready_o[1] !== 1'b0) begin
      bad++;
      $display("FAIL full_level: got level=%0d ready=%b, required 4/0", lvl(1), ch_desc_ready_o[1]);
    end
    do_push(1, mk(32'hDEAD, 32'hBEEF, 32'd1), 1'b1, acc);
    total++;
    if (acc !== 1'b0 || lvl(1) !== 3'd4) begin
      bad++;
      $display("FAIL full_refuse: got accepted=%b level=%0d, required 0/4", acc, lvl(1));
    end
    handshake();
    complete(1'b0, 1'b1);
    tick();
    total++;
    if (lvl(1) !== 3'd3 || ch_desc_ready_o[1] !== 1'b1) begin
      bad++;
      $display("FAIL full_after_pop: got level=%0d ready=%b, required 3/1", lvl(1), ch_desc_ready_o[1]);
    end
    do_push(1, mk(32'hC000, 32'hC100, 32'd200), 1'b1, acc);
    total++;
    if (acc !== 1'b1 || lvl(1) !== 3'd4) begin
      bad++;
      $display("FAIL full_wrap_push: got accepted=%b level=%0d, required 1/4", acc, lvl(1));
    end
    for (int k = 0; k < DEPTH + 1; k++) begin
      wait_issue("full");
      handshake();
      complete(1'b0, 1'b1);
    end
    total++;
    if (lvl(1) !== 3'd0 || sts(1) !== 3'b010) begin
      bad++;
      $display("FAIL full_drain: got level=%0d status=%b, required 0/010", lvl(1), sts(1));
    end
  endtask

  task automatic test_error();
    bit acc;
    apply_reset();
    do_push(2, mk(32'h1, 32'h2, 32'd8), 1'b1, acc);
    do_push(2, mk(32'h3, 32'h4, 32'd8), 1'b0, acc);
    do_push(2, mk(32'h5, 32'h6, 32'd8), 1'b0, acc);
    total++;
    if (lvl(2) !== 3'd2) begin
      bad++;
      $display("FAIL err_pre_level: got %0d, required 2", lvl(2));
    end
    wait_issue("err");
    handshake();
    err_src_i = 2'd1;
    err_addr_i = 32'h1000;
    complete(1'b1, 1'b1);
    total++;
    if (lvl(2) !== 3'd0 || sts(2) !== 3'b100) begin
      bad++;
      $display("FAIL err_status: got level=%0d status=%b, required 0/100", lvl(2), sts(2));
    end
    total++;
    if (err_ch_o !== 2'd2 || err_src_o !== 2'd1 || err_addr_o !== 32'h1000) begin
      bad++;
      $display("FAIL err_capture: got ch=%0d src=%0d addr=%h, required 2/1/1000", err_ch_o, err_src_o, err_addr_o);
    end
    do_push(2, mk(32'h7, 32'h8, 32'd8), 1'b0, acc);
    total++;
    if (acc !== 1'b0) begin
      bad++;
      $display("FAIL err_refuse: got accepted=%b, required 0", acc);
    end
    repeat (3) begin
      tick();
      total++;
      if (issue_valid_o !== 1'b0) begin
        bad++;
        $display("FAIL err_no_issue: got issue_valid_o=%b, required 0", issue_valid_o);
      end
    end
    ch_clear_i[2] = 1'b1;
    tick();
    ch_clear_i[2] = 1'b0;
    total++;
    if (sts(2) !== 3'b000 || ch_desc_ready_o[2] !== 1'b1) begin
      bad++;
      $display("FAIL err_clear: got status=%b ready=%b, required 000/1", sts(2), ch_desc_ready_o[2]);
    end
  endtask

  task automatic test_zero_len();
    bit acc;
    apply_reset();
    do_push(3, mk(32'h4000, 32'h5000, 32'd0), 1'b0, acc);
    total++;
    if (sts(3) !== 3'b001 || issue_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL zero_pending: got status=%b valid=%b, required 001/0", sts(3), issue_valid_o);
    end
    tick();
    total++;
    if (sts(3) !== 3'b010 || lvl(3) !== 3'd0) begin
      bad++;
      $display("FAIL zero_done: got status=%b level=%0d, required 010/0", sts(3), lvl(3));
    end
    repeat (3) begin
      total++;
      if (issue_valid_o !== 1'b0) begin
        bad++;
        $display("FAIL zero_no_issue: got issue_valid_o=%b, required 0", issue_valid_o);
      end
      tick();
    end
  endtask

  task automatic test_abort();
    bit acc;
    apply_reset();
    do_push(0, mk(32'h11, 32'h22, 32'd48), 1'b1, acc);
    do_push(0, mk(32'h33, 32'h44, 32'd48), 1'b0, acc);
    total++;
    if (lvl(0) !== 3'd1) begin
      bad++;
      $display("FAIL abort_pre_level: got %0d, required 1", lvl(0));
    end
    wait_issue("abort");
    handshake();
    ch_abort_i[0] = 1'b1;
    do_push(0, mk(32'h55, 32'h66, 32'd48), 1'b0, acc);
    ch_abort_i[0] = 1'b0;
    total++;
    if (acc !== 1'b0 || lvl(0) !== 3'd0 || sts(0) !== 3'b001) begin
      bad++;
      $display("FAIL abort_flush: got accepted=%b level=%0d status=%b, required 0/0/001", acc, lvl(0), sts(0));
    end
    ch_clear_i[0] = 1'b1;
    complete(1'b0, 1'b1);
    ch_clear_i[0] = 1'b0;
    total++;
    if (sts(0) !== 3'b010) begin
      bad++;
      $display("FAIL abort_done: got %b, required 010", sts(0));
    end
    repeat (3) begin
      tick();
      total++;
      if (issue_valid_o !== 1'b0) begin
        bad++;
        $display("FAIL abort_no_issue: got issue_valid_o=%b, required 0", issue_valid_o);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit acc;
    apply_reset();
    do_push(1, mk(32'h99, 32'h98, 32'd12), 1'b1, acc);
    wait_issue("rstmid");
    handshake();
    apply_reset();
    complete(1'b0, 1'b1);
    total++;
    if (sts(1) !== 3'b000 || issue_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_ignore: got status=%b valid=%b, required 000/0", sts(1), issue_valid_o);
    end
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_in_order();
    test_round_robin();
    test_full();
    test_error();
    test_zero_len();
    test_abort();
    test_reset_mid();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_leftover: got %0d pending, required 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
